// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 640x480 text-mode VGA renderer fed by screen RAM and font ROM
module vga_text_renderer #(
  parameter int          H_VIS       = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_VIS       = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter logic [11:0] FG_COLOR    = 12'hFFF,
  parameter logic [11:0] BG_COLOR    = 12'h000,
  parameter logic [11:0] CURSOR_ADDR = 12'd2485,
  parameter int          BLINK_LOG2  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] ram_addr,
  input  logic [7:0]  ram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0]          h_cnt, v_cnt;
  logic [BLINK_LOG2:0] blink_cnt;
  logic                h_last, v_last, visible, hs_raw, vs_raw, origin;

  // stage 1 registers (one clock behind the counters)
  logic       vis_d1, hs_d1, vs_d1, org_d1, cur_d1;
  logic [2:0] col_d1;
  logic [3:0] row_d1;
  // stage 2 registers (two clocks behind the counters)
  logic       vis_d2, hs_d2, vs_d2, org_d2, cur_d2;
  logic [2:0] col_d2;
  logic       pix_bit, invert;

  // raster position decode and screen RAM address
  always_comb begin
    h_last   = (h_cnt == H_LAST);
    v_last   = (v_cnt == V_LAST);
    visible  = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
    hs_raw   = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    vs_raw   = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
    origin   = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    ram_addr = visible ? {v_cnt[8:4], h_cnt[9:3]} : 12'd0;
  end

  // horizontal/vertical raster counters and free-running frame counter for blink
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= 10'd0;
      v_cnt     <= 10'd0;
      blink_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= 10'd0;
      if (v_last) begin
        v_cnt     <= 10'd0;
        blink_cnt <= blink_cnt + 1'b1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // carry position attributes alongside the RAM read; cursor match taken from the issued address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d1 <= 1'b0;
      hs_d1  <= 1'b1;
      vs_d1  <= 1'b1;
      org_d1 <= 1'b0;
      cur_d1 <= 1'b0;
      col_d1 <= 3'd0;
      row_d1 <= 4'd0;
    end else begin
      vis_d1 <= visible;
      hs_d1  <= hs_raw;
      vs_d1  <= vs_raw;
      org_d1 <= origin;
      cur_d1 <= (ram_addr == CURSOR_ADDR);
      col_d1 <= h_cnt[2:0];
      row_d1 <= v_cnt[3:0];
    end
  end

  // glyph row lookup; held at zero outside the visible area so reset and blanking are quiet
  always_comb begin
    font_addr = vis_d1 ? {ram_data, row_d1} : 12'd0;
  end

  // carry attributes alongside the font ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d2 <= 1'b0;
      hs_d2  <= 1'b1;
      vs_d2  <= 1'b1;
      org_d2 <= 1'b0;
      cur_d2 <= 1'b0;
      col_d2 <= 3'd0;
    end else begin
      vis_d2 <= vis_d1;
      hs_d2  <= hs_d1;
      vs_d2  <= vs_d1;
      org_d2 <= org_d1;
      cur_d2 <= cur_d1;
      col_d2 <= col_d1;
    end
  end

  // pick the pixel out of the glyph row (bit 7 is leftmost) and apply cursor blink inversion
  always_comb begin
    pix_bit = font_data[3'd7 - col_d2];
    invert  = cur_d2 & blink_cnt[BLINK_LOG2];
  end

  // registered outputs; blanking forces black regardless of glyph or cursor
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb         <= 12'h000;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (!vis_d2) begin
        rgb <= 12'h000;
      end else if (pix_bit ^ invert) begin
        rgb <= FG_COLOR;
      end else begin
        rgb <= BG_COLOR;
      end
      hsync       <= hs_d2;
      vsync       <= vs_d2;
      frame_start <= org_d2;
    end
  end

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - self-checking bench for vga_text_renderer on a reduced raster
module tb_vga_text_renderer;

  localparam int HV = 96, HF = 8, HS = 16, HB = 8;
  localparam int HT = HV + HF + HS + HB;
  localparam int VV = 32, VF = 3, VS = 2, VB = 5;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int BL = 1;
  localparam int CUR = 137;   // row 1, col 9
  localparam int TCH = 132;   // row 1, col 4
  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] ram_addr, font_addr, rgb;
  logic [7:0]  ram_data, font_data;
  logic        hsync, vsync, frame_start;

  logic [7:0] screen [0:4095];
  logic [7:0] font   [0:4095];

  int n_cmp = 0;
  int n_bad = 0;

  vga_text_renderer #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FG_COLOR(FG), .BG_COLOR(BG),
    .CURSOR_ADDR(12'(CUR)), .BLINK_LOG2(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .font_addr(font_addr), .font_data(font_data),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // registered-read screen RAM and font ROM
  always @(posedge clk) begin
    ram_data  <= screen[ram_addr];
    font_data <= font[font_addr];
  end

  // reference model: pos = pixel clocks since reset release at the raster origin
  function automatic bit is_vis(input int pos);
    return (pos >= 0) && ((pos % HT) < HV) && (((pos / HT) % VT) < VV);
  endfunction

  function automatic int cell_addr(input int pos);
    return ((((pos / HT) % VT) / 16) * 128) + ((pos % HT) / 8);
  endfunction

  function automatic logic [11:0] exp_rgb(input int pos);
    int h, v, code, g, b, inv;
    if (!is_vis(pos)) return 12'h000;
    h = pos % HT;
    v = (pos / HT) % VT;
    code = int'(screen[cell_addr(pos)]);
    g = int'(font[code * 16 + v % 16]);
    b = (g >> (7 - h % 8)) & 1;
    inv = (cell_addr(pos) == CUR && (((pos / FR) >> BL) & 1) == 1) ? 1 : 0;
    return ((b ^ inv) == 1) ? FG : BG;
  endfunction

  function automatic logic exp_hs(input int pos);
    int h;
    if (pos < 0) return 1'b1;
    h = pos % HT;
    return !(h >= HV + HF && h < HV + HF + HS);
  endfunction

  function automatic logic exp_vs(input int pos);
    int v;
    if (pos < 0) return 1'b1;
    v = (pos / HT) % VT;
    return !(v >= VV + VF && v < VV + VF + VS);
  endfunction

  function automatic logic exp_fs(input int pos);
    return (pos >= 0) && (pos % FR == 0);
  endfunction

  function automatic logic [11:0] exp_ra(input int pos);
    return is_vis(pos) ? 12'(cell_addr(pos)) : 12'd0;
  endfunction

  function automatic logic [11:0] exp_fa(input int pos);
    return {screen[cell_addr(pos)], 4'(((pos / HT) % VT) % 16)};
  endfunction

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL reset_rgb got %h want 000", rgb); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL reset_hsync got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL reset_vsync got %b want 1", vsync); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    n_cmp++; if (ram_addr !== 12'd0) begin n_bad++; $display("FAIL reset_ram_addr got %h want 000", ram_addr); end
    n_cmp++; if (font_addr !== 12'd0) begin n_bad++; $display("FAIL reset_font_addr got %h want 000", font_addr); end
  endtask

  task automatic test_frames();
    int last_hf, last_vf, last_fs, pos, base, want;
    logic ph, pv;
    logic [11:0] gl [8];
    gl = '{FG, FG, BG, BG, BG, BG, FG, FG};
    for (int i = 0; i < 4096; i++) begin
      screen[i] = 8'($urandom);
      font[i]   = 8'($urandom);
    end
    screen[TCH] = 8'h41;
    font[12'h415] = 8'hC3;
    base = 21 * HT + 32;
    last_hf = -1; last_vf = -1; last_fs = -1; ph = 1'b1; pv = 1'b1;
    release_reset();
    for (int k = 1; k <= 2 * FR + 8; k++) begin
      @(negedge clk);
      pos = k - 3;
      n_cmp++; if (rgb !== exp_rgb(pos)) begin n_bad++; $display("FAIL frames_rgb k=%0d got %h want %h", k, rgb, exp_rgb(pos)); end
      n_cmp++; if (hsync !== exp_hs(pos)) begin n_bad++; $display("FAIL frames_hsync k=%0d got %b want %b", k, hsync, exp_hs(pos)); end
      n_cmp++; if (vsync !== exp_vs(pos)) begin n_bad++; $display("FAIL frames_vsync k=%0d got %b want %b", k, vsync, exp_vs(pos)); end
      n_cmp++; if (frame_start !== exp_fs(pos)) begin n_bad++; $display("FAIL frames_fs k=%0d got %b want %b", k, frame_start, exp_fs(pos)); end
      n_cmp++; if (ram_addr !== exp_ra(k)) begin n_bad++; $display("FAIL frames_ram_addr k=%0d got %h want %h", k, ram_addr, exp_ra(k)); end
      if (is_vis(k - 1)) begin
        n_cmp++; if (font_addr !== exp_fa(k - 1)) begin n_bad++; $display("FAIL frames_font_addr k=%0d got %h want %h", k, font_addr, exp_fa(k - 1)); end
      end
      if (pos >= base && pos < base + 8) begin
        n_cmp++; if (rgb !== gl[pos - base]) begin n_bad++; $display("FAIL glyph41_rgb i=%0d got %h want %h", pos - base, rgb, gl[pos - base]); end
      end
      if (k >= base && k < base + 8) begin
        n_cmp++; if (ram_addr !== 12'd132) begin n_bad++; $display("FAIL glyph41_ram_addr got %0d want 132", ram_addr); end
      end
      if (k - 1 >= base && k - 1 < base + 8) begin
        n_cmp++; if (font_addr !== 12'h415) begin n_bad++; $display("FAIL glyph41_font_addr got %h want 415", font_addr); end
      end
      if (ph && !hsync) begin
        if (last_hf >= 0) begin
          n_cmp++; if (k - last_hf != HT) begin n_bad++; $display("FAIL hsync_period got %0d want %0d", k - last_hf, HT); end
        end
        last_hf = k;
      end
      if (!ph && hsync) begin
        n_cmp++; if (k - last_hf != HS) begin n_bad++; $display("FAIL hsync_width got %0d want %0d", k - last_hf, HS); end
      end
      if (pv && !vsync) begin
        if (last_vf >= 0) begin
          n_cmp++; if (k - last_vf != FR) begin n_bad++; $display("FAIL vsync_period got %0d want %0d", k - last_vf, FR); end
        end
        last_vf = k;
      end
      if (!pv && vsync) begin
        n_cmp++; if (k - last_vf != VS * HT) begin n_bad++; $display("FAIL vsync_width got %0d want %0d", k - last_vf, VS * HT); end
      end
      if (frame_start) begin
        want = (last_fs < 0) ? 3 : last_fs + FR;
        n_cmp++; if (k != want) begin n_bad++; $display("FAIL frame_start_time got %0d want %0d", k, want); end
        last_fs = k;
      end
      ph = hsync;
      pv = vsync;
    end
    n_cmp++; if (last_fs != 2 * FR + 3) begin n_bad++; $display("FAIL frame_start_last got %0d want %0d", last_fs, 2 * FR + 3); end
    n_cmp++; if (last_vf < 0) begin n_bad++; $display("FAIL vsync_seen got %0d want >=0", last_vf); end
  endtask

  task automatic test_all_ff();
    logic [11:0] want;
    for (int i = 0; i < 4096; i++) begin
      screen[i] = 8'($urandom);
      font[i]   = 8'hFF;
    end
    release_reset();
    for (int k = 1; k <= FR + 5; k++) begin
      @(negedge clk);
      want = is_vis(k - 3) ? FG : 12'h000;
      n_cmp++; if (rgb !== want) begin n_bad++; $display("FAIL all_ff_rgb k=%0d got %h want %h", k, rgb, want); end
    end
  endtask

  task automatic test_cursor();
    int pos;
    logic [11:0] want;
    for (int i = 0; i < 4096; i++) begin
      screen[i] = 8'h00;
      font[i]   = 8'h00;
    end
    release_reset();
    for (int k = 1; k <= 3 * FR + 5; k++) begin
      @(negedge clk);
      pos = k - 3;
      want = (is_vis(pos) && cell_addr(pos) == CUR && (((pos / FR) >> BL) & 1) == 1) ? FG : BG;
      n_cmp++; if (rgb !== want) begin n_bad++; $display("FAIL cursor_rgb k=%0d got %h want %h", k, rgb, want); end
    end
  endtask

  task automatic test_midline_reset();
    int tgt [2];
    int found;
    tgt = '{5 * HT + 50, 3 * HT + HV + HF + 4};
    for (int i = 0; i < 4096; i++) begin
      screen[i] = 8'($urandom);
      font[i]   = 8'hFF;
    end
    for (int t = 0; t < 2; t++) begin
      release_reset();
      for (int k = 1; k <= tgt[t]; k++) @(negedge clk);
      n_cmp++; if (rgb !== exp_rgb(tgt[t] - 3) || hsync !== exp_hs(tgt[t] - 3)) begin
        n_bad++; $display("FAIL midreset_pre t=%0d got %h/%b want %h/%b", t, rgb, hsync, exp_rgb(tgt[t] - 3), exp_hs(tgt[t] - 3));
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (rgb !== 12'h000) begin n_bad++; $display("FAIL midreset_rgb t=%0d got %h want 000", t, rgb); end
      n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL midreset_hsync t=%0d got %b want 1", t, hsync); end
      n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL midreset_vsync t=%0d got %b want 1", t, vsync); end
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (ram_addr !== 12'd0) begin n_bad++; $display("FAIL midreset_ram_addr t=%0d got %h want 000", t, ram_addr); end
      found = -1;
      for (int k = 1; k <= 2 * HT && found < 0; k++) begin
        @(negedge clk);
        if (!hsync) found = k;
      end
      n_cmp++; if (found != HV + HF + 3) begin n_bad++; $display("FAIL midreset_first_hsync t=%0d got %0d want %0d", t, found, HV + HF + 3); end
    end
  endtask

  task automatic test_upstream_write();
    for (int i = 0; i < 4096; i++) begin
      screen[i] = 8'($urandom);
      font[i]   = 8'($urandom);
    end
    for (int r = 0; r < 16; r++) begin
      font[12'h200 + r] = 8'h00;
      font[12'h350 + r] = 8'($urandom) | 8'h81;
    end
    screen[CUR]     = 8'h20;
    screen[CUR - 1] = 8'h20;
    release_reset();
    for (int k = 1; k <= 2 * FR + 3; k++) begin
      @(negedge clk);
      if (k == 35 * HT) screen[CUR] = 8'h35;
      if (k == FR + 5 * HT) screen[CUR - 1] = 8'h35;
      n_cmp++; if (rgb !== exp_rgb(k - 3)) begin n_bad++; $display("FAIL upstream_rgb k=%0d got %h want %h", k, rgb, exp_rgb(k - 3)); end
      n_cmp++; if (ram_addr !== exp_ra(k)) begin n_bad++; $display("FAIL upstream_ram_addr k=%0d got %h want %h", k, ram_addr, exp_ra(k)); end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_all_ff();
    test_cursor();
    test_midline_reset();
    test_upstream_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_text_renderer.md
Name: vga_text_renderer

Overview:
- Downstream consumer of the 4096x8 character screen RAM: generates 640x480@60 VGA timing, drives the RAM read address, fetches the returned ASCII code through an external synchronous font ROM, and produces pixel colour plus aligned sync.
- Character cell is 8x16 pixels, giving 80 visible columns x 30 rows.
- Screen RAM row stride is 128, so address = {char_row[4:0], char_col[6:0]}.
- Includes a frame counter for a blinking cursor cell and a frame-start strobe for the upstream writer.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- FG_COLOR, 12'hFFF, RGB444 foreground
- BG_COLOR, 12'h000, RGB444 background
- CURSOR_ADDR, 12'd2485, screen address of the blinking cursor cell
- BLINK_LOG2, 5, blink half-period = 2^BLINK_LOG2 frames

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- rst_n  in  1  asynchronous active-low reset
- ram_addr  out  12  screen RAM read address
- ram_data  in  8  character code, valid one clk after ram_addr (registered read)
- font_addr  out  12  font ROM address = {char_code, glyph_row[3:0]}
- font_data  in  8  glyph row bits, valid one clk after font_addr; bit 7 = leftmost pixel
- rgb  out  12  {R[3:0],G[3:0],B[3:0]}
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- frame_start  out  1  one-cycle pulse, aligned with first visible pixel of each frame at the rgb output

Behaviour:
- Reset, asynchronous while rst_n=0:
  - h_cnt=0, v_cnt=0, blink counter=0.
  - All pipeline registers cleared to blank/inactive.
  - Outputs: rgb=0, hsync=1, vsync=1, frame_start=0, ram_addr=0, font_addr=0.
- Counters:
  - h_cnt counts 0..H_TOT-1 (800), then wraps to 0 and increments v_cnt.
  - v_cnt counts 0..V_TOT-1 (525), then wraps to 0.
  - Frame boundary occurs on the clock where h_cnt=799 and v_cnt=524.
- Stage 0, cycle t:
  - ram_addr = {v_cnt[8:4], h_cnt[9:3]} when visible (h_cnt<640 and v_cnt<480); otherwise ram_addr holds 0.
  - ram_addr is driven from registered counters, so it is glitch-free.
- Stage 1, cycle t+1:
  - ram_data is valid.
  - font_addr = {ram_data, v_cnt[3:0] delayed 1}.
  - Cursor match flag = (ram_addr delayed 1 == CURSOR_ADDR).
- Stage 2, cycle t+2:
  - font_data is valid.
  - pixel bit = font_data[7 - h_cnt[2:0] delayed 2].
- Stage 3, registered output at t+3:
  - rgb = FG_COLOR if bit=1, otherwise BG_COLOR.
  - If the cursor flag is set and blink phase = 1, colours are inverted: bit=1 gives BG_COLOR, bit=0 gives FG_COLOR.
  - If the visible flag (delayed 3) is 0, rgb = 12'h000 regardless of any other input.
- Sync:
  - hsync is low for h_cnt in [656,751]; vsync is low for v_cnt in [490,491].
  - Both are delayed 3 cycles so they stay aligned with rgb.
  - Total pipeline latency from counter value to rgb/sync is 3 clocks, constant.
- Blink:
  - The frame counter increments once per frame boundary.
  - Blink phase = counter bit BLINK_LOG2; the counter wraps freely.
- frame_start:
  - Asserted for exactly one clk when the delayed-3 counter position is (0,0).
  - The first pulse after reset release occurs 3 clks after release, because counters start at (0,0).
- Reset mid-frame:
  - Outputs go inactive immediately (asynchronous).
  - After release, timing restarts from (0,0) and the pipeline fills with blank, so no stale pixels are emitted.
- Columns 80..127 and rows 30..31 of screen RAM are never addressed.

Test Plan:
- Reset release, run 2 frames:
  - hsync period 800 clks, low for 96 clks.
  - vsync period 420000 clks, low for 1600 clks.
  - frame_start pulses 420000 clks apart, first at clk 3 after release.
- Screen model with code 0x41 at address 2467 (row 19, col 35); font model row 5 of 0x41 = 8'b1100_0011:
  - At h_cnt=280..287, v_cnt=309, ram_addr=2467 and font_addr=0x415.
  - rgb 3 clks later = FFF,FFF,000,000,000,000,FFF,FFF.
- All-0xFF font:
  - rgb=FFF for every visible pixel.
  - rgb=000 for h_cnt 640..799 and v_cnt 480..524 (blanking forced).
- Cursor cell 2485 with glyph all-zero:
  - Frames 0..31 give rgb=000 (BG) on that 8x16 cell.
  - Frames 32..63 give rgb=FFF there; all other cells stay BG.
- Assert rst_n=0 mid-line at h_cnt=300:
  - rgb=0, hsync=1, vsync=1 in the same cycle.
  - After release, ram_addr=0 and the first hsync low begins at output cycle 656+3.
- Upstream write of 0x35 to address 2485 during a frame:
  - The cell shows the glyph of '5' starting from the next frame's fetch of row 19 (or the current frame if the write precedes that fetch).
